// File: rtl/boron_pkg.sv
// -----------------------------------------------------------------------------
// boron_pkg
//   Shared definitions for the BORON sequencing controller: default round
//   count and round-index width, the controller state encoding, and the
//   operand widths used on the job and datapath ports.
// -----------------------------------------------------------------------------
package boron_pkg;

    // One load round plus 24 iterated rounds; the last one applies whitening.
    localparam int DEF_ROUNDS = 25;
    localparam int DEF_RW     = 5;
    localparam int LAST_ROUND = DEF_ROUNDS - 1;

    localparam int BLOCK_W = 64;
    localparam int KEY_W   = 128;

    typedef logic [BLOCK_W-1:0] block_t;
    typedef logic [KEY_W-1:0]   key_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage : boron_pkg

// File: rtl/boron_round_cnt.sv
// -----------------------------------------------------------------------------
// boron_round_cnt
//   Round index counter for the BORON datapath. Clears to zero, advances by one
//   when enabled, and saturates at LAST so the index can never run past the
//   final round.
//
// Ports:
//   clk    in   clock, rising edge
//   reset  in   asynchronous active-low reset
//   clr    in   synchronous clear to 0 (wins over inc)
//   inc    in   advance by one unless already at LAST
//   cnt    out  current round index (registered)
//   last   out  cnt == LAST
// -----------------------------------------------------------------------------
module boron_round_cnt
    import boron_pkg::*;
#(
    parameter int RW   = DEF_RW,
    parameter int LAST = LAST_ROUND
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          inc,
    output logic [RW-1:0] cnt,
    output logic          last
);

    localparam logic [RW-1:0] LAST_V = RW'(LAST);

    assign last = (cnt == LAST_V);

    // NOTE: registers are assigned with <= so every flop samples the values
    // from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !last) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule : boron_round_cnt

// File: rtl/boron_ctrl.sv
// -----------------------------------------------------------------------------
// boron_ctrl
//   Sequencing controller for the BORON 64-bit block / 128-bit key round
//   datapath. Accepts a job on the input handshake, latches the operands,
//   steps the datapath through one load round and ROUNDS-1 iterated rounds,
//   captures the whitened ciphertext and offers it on the output handshake.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-low reset
//   in_valid   in   job request
//   in_ready   out  job can be accepted this cycle
//   in_pt      in   plaintext, sampled on accept
//   in_key     in   key, sampled on accept
//   abort      in   synchronous cancel of the current job
//   out_valid  out  ciphertext available
//   out_ready  in   consumer takes the ciphertext
//   out_ct     out  ciphertext, held while out_valid & !out_ready
//   busy       out  job in LOAD or RUN
//   dp_pt      out  latched plaintext to datapath
//   dp_key     out  latched key to datapath
//   dp_select  out  1 = datapath loads dp_pt, 0 = round feedback
//   dp_round   out  round index to datapath / key schedule
//   dp_ct      in   datapath result, whitened when dp_round = ROUNDS-1
// -----------------------------------------------------------------------------
module boron_ctrl
    import boron_pkg::*;
#(
    parameter int ROUNDS = DEF_ROUNDS,
    parameter int RW     = DEF_RW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  block_t        in_pt,
    input  key_t          in_key,
    input  logic          abort,
    output logic          out_valid,
    input  logic          out_ready,
    output block_t        out_ct,
    output logic          busy,
    output block_t        dp_pt,
    output key_t          dp_key,
    output logic          dp_select,
    output logic [RW-1:0] dp_round,
    input  block_t        dp_ct
);

    localparam int LAST = ROUNDS - 1;

    state_t state;
    logic   accept;
    logic   cnt_clr;
    logic   cnt_inc;
    logic   cnt_last;

    // A finished result leaves DONE on the same edge a new job is taken, so
    // with out_ready held high the DONE cycle overlaps the next accept.
    assign in_ready = !abort &&
                      ((state == ST_IDLE) || ((state == ST_DONE) && out_ready));
    assign accept   = in_valid && in_ready;

    // Counter control: cleared on accept, abort and completion; advanced in
    // LOAD (0 -> 1) and through RUN until the final round.
    // NOTE: both outputs get a default before any branch, so no path leaves
    // them unassigned and no latch is inferred.
    always_comb begin
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        if (abort || accept) begin
            cnt_clr = 1'b1;
        end else if (state == ST_LOAD) begin
            cnt_inc = 1'b1;
        end else if (state == ST_RUN) begin
            if (cnt_last) begin
                cnt_clr = 1'b1;
            end else begin
                cnt_inc = 1'b1;
            end
        end
    end

    boron_round_cnt #(
        .RW   (RW),
        .LAST (LAST)
    ) u_round_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .cnt   (dp_round),
        .last  (cnt_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            out_ct    <= '0;
            busy      <= 1'b0;
            dp_pt     <= '0;
            dp_key    <= '0;
            dp_select <= 1'b0;
        end else if (abort) begin
            // Operands and the last ciphertext stay put; only control drops.
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            dp_select <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state <= ST_IDLE;
                end
                ST_LOAD: begin
                    state     <= ST_RUN;
                    dp_select <= 1'b0;
                end
                ST_RUN: begin
                    if (cnt_last) begin
                        out_ct    <= dp_ct;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            // Accept is only possible from IDLE or DONE; it overrides the
            // IDLE target chosen above.
            if (accept) begin
                dp_pt     <= in_pt;
                dp_key    <= in_key;
                dp_select <= 1'b1;
                busy      <= 1'b1;
                state     <= ST_LOAD;
            end
        end
    end

endmodule : boron_ctrl

// File: tb/tb_boron_ctrl.sv
// -----------------------------------------------------------------------------
// tb_boron_ctrl
//   Self-checking bench for boron_ctrl. A stand-in datapath drives dp_ct from
//   the controller's operand and round outputs; a job-level reference model
//   (job age in cycles, pending result) predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_boron_ctrl;
    import boron_pkg::*;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  in_pt;
    logic [127:0] in_key;
    logic         abort;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  out_ct;
    logic         busy;
    logic [63:0]  dp_pt;
    logic [127:0] dp_key;
    logic         dp_select;
    logic [4:0]   dp_round;
    logic [63:0]  dp_ct;

    int n_tests = 0;
    int n_fail  = 0;

    // Job-level reference model state.
    bit           m_active;
    bit           m_pending;
    int           m_age;
    logic [63:0]  m_pt;
    logic [127:0] m_key;
    logic [63:0]  m_ct;

    // Stand-in round datapath: result depends on operands and round index.
    function automatic logic [63:0] ref_ct(input logic [63:0] pt,
                                           input logic [127:0] key,
                                           input int unsigned rnd);
        logic [63:0] x;
        x = pt ^ key[63:0];
        x = {x[50:0], x[63:51]} ^ key[127:64];
        x = x + 64'(rnd) * 64'h9E37_79B9_7F4A_7C15;
        return x;
    endfunction

    assign dp_ct = ref_ct(dp_pt, dp_key, 32'(dp_round));

    boron_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pt     (in_pt),
        .in_key    (in_key),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ct    (out_ct),
        .busy      (busy),
        .dp_pt     (dp_pt),
        .dp_key    (dp_key),
        .dp_select (dp_select),
        .dp_round  (dp_round),
        .dp_ct     (dp_ct)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active  = 0;
        m_pending = 0;
        m_age     = 0;
        m_pt      = '0;
        m_key     = '0;
        m_ct      = '0;
    endtask

    task automatic check_outputs();
        check("out_valid", 128'(out_valid), 128'(m_pending));
        check("busy", 128'(busy), 128'(m_active));
        check("dp_select", 128'(dp_select), 128'(m_active && m_age == 0));
        check("dp_round", 128'(dp_round), m_active ? 128'(m_age) : 128'(0));
        check("dp_pt", 128'(dp_pt), 128'(m_pt));
        check("dp_key", dp_key, m_key);
        check("out_ct", 128'(out_ct), 128'(m_ct));
    endtask

    // One clock with the current inputs; model advanced, outputs checked.
    task automatic tick();
        bit exp_ready;
        bit acc;
        #1;
        exp_ready = !abort && ((!m_active && !m_pending) || (m_pending && out_ready));
        check("in_ready", 128'(in_ready), 128'(exp_ready));
        acc = in_valid && exp_ready;
        @(posedge clk);
        if (abort) begin
            m_active  = 0;
            m_pending = 0;
        end else begin
            if (m_pending && out_ready) m_pending = 0;
            if (m_active && m_age == LAST_ROUND) begin
                m_active  = 0;
                m_pending = 1;
                m_ct      = ref_ct(m_pt, m_key, LAST_ROUND);
            end else if (m_active) begin
                m_age++;
            end
            if (acc) begin
                m_active = 1;
                m_age    = 0;
                m_pt     = in_pt;
                m_key    = in_key;
            end
        end
        #1;
        check_outputs();
    endtask

    // Cycles until out_valid is seen, or -1 if the budget runs out.
    task automatic run_until_valid(input int budget, output int n);
        n = -1;
        for (int i = 0; i < budget && n < 0; i++) begin
            tick();
            if (out_valid) n = i + 1;
        end
    endtask

    task automatic run_to_round(input int r);
        int guard;
        guard = 0;
        while (!(m_active && m_age == r) && guard < 40) begin
            tick();
            guard++;
        end
        check("reach_round", 128'(dp_round), 128'(r));
    endtask

    // Reset asserted mid-cycle: outputs must drop before any clock edge.
    task automatic apply_reset();
        reset     = 1'b0;
        in_valid  = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("ready_after_reset", 128'(in_ready), 128'(1));
    endtask

    task automatic submit(input logic [63:0] pt, input logic [127:0] key);
        in_pt    = pt;
        in_key   = key;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    typedef struct {
        logic [63:0]  pt;
        logic [127:0] key;
        int           stall;
        int           abort_at;
        bit           exp_done;
        logic [63:0]  exp_ct;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int          n;
        logic [63:0] saved;

        vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, {128{1'b1}}, 0, -1, 1'b1, 64'h0};
        vecs[1] = '{64'h8000_0000_0000_0001, 128'h1, 3, -1, 1'b1, 64'h0};
        vecs[2] = '{64'hDEAD_BEEF_CAFE_F00D, 128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100, 0, 1, 1'b0, 64'h0};
        vecs[3] = '{64'h1234_5678_9ABC_DEF0, 128'hA5A5_A5A5_5A5A_5A5A_0000_FFFF_1111_2222, 5, -1, 1'b1, 64'h0};
        vecs[4] = '{64'h0000_0000_FFFF_0000, 128'h0, 0, 0, 1'b0, 64'h0};
        vecs[5] = '{64'h7777_0000_3333_1111, 128'hFEDC_BA98_7654_3210_0123_4567_89AB_CDEF, 1, -1, 1'b1, 64'h0};
        foreach (vecs[i]) vecs[i].exp_ct = ref_ct(vecs[i].pt, vecs[i].key, LAST_ROUND);

        in_pt  = '0;
        in_key = '0;
        apply_reset();

        // Zero job: 25-cycle latency, full round sequence tracked by model.
        submit(64'h0, 128'h0);
        run_until_valid(40, n);
        check("latency_zero", 128'(n), 128'(25));
        check("ct_zero", 128'(out_ct), 128'(ref_ct(64'h0, 128'h0, LAST_ROUND)));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Output stall: result held, no new accept despite in_valid.
        submit(64'h0123_4567_89AB_CDEF, 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF);
        run_until_valid(40, n);
        check("latency_stall", 128'(n), 128'(25));
        saved = out_ct;
        check("ct_stall", 128'(saved),
              128'(ref_ct(64'h0123_4567_89AB_CDEF, 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF, LAST_ROUND)));
        in_valid = 1'b1;
        in_pt    = 64'h5555_AAAA_5555_AAAA;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("stall_ct_hold", 128'(out_ct), 128'(saved));
            check("stall_in_ready", 128'(in_ready), 128'(0));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("stall_release", 128'(out_valid), 128'(0));
        out_ready = 1'b0;

        // Back-to-back: second job accepted on first's DONE cycle.
        out_ready = 1'b1;
        submit(64'hAAAA_0000_BBBB_1111, 128'h1);
        in_valid = 1'b1;
        in_pt    = 64'hCCCC_2222_DDDD_3333;
        in_key   = 128'h2;
        run_until_valid(40, n);
        check("b2b_first_latency", 128'(n), 128'(25));
        check("b2b_first_ct", 128'(out_ct), 128'(ref_ct(64'hAAAA_0000_BBBB_1111, 128'h1, LAST_ROUND)));
        run_until_valid(40, n);
        check("b2b_spacing", 128'(n), 128'(26));
        check("b2b_second_ct", 128'(out_ct), 128'(ref_ct(64'hCCCC_2222_DDDD_3333, 128'h2, LAST_ROUND)));
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;

        // Abort mid-job, then a fresh job completes normally.
        submit(64'h1111_2222_3333_4444, 128'h55);
        run_to_round(12);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", 128'(busy), 128'(0));
        run_until_valid(30, n);
        check("abort_no_valid", 128'(n), -128'sd1);
        submit(64'h9999_8888_7777_6666, 128'h66);
        check("fresh_round", 128'(dp_round), 128'(0));
        run_until_valid(40, n);
        check("after_abort_latency", 128'(n), 128'(25));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Abort on the final RUN edge: nothing captured.
        submit(64'h0F0F_0F0F_F0F0_F0F0, 128'h77);
        run_to_round(LAST_ROUND);
        saved = out_ct;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("final_abort_ct", 128'(out_ct), 128'(saved));
        check("final_abort_valid", 128'(out_valid), 128'(0));

        // Abort with in_valid in IDLE: no accept.
        abort    = 1'b1;
        in_valid = 1'b1;
        tick();
        check("idle_abort_busy", 128'(busy), 128'(0));
        abort    = 1'b0;
        in_valid = 1'b0;
        tick();

        // Asynchronous reset mid-job.
        submit(64'h2468_ACE0_1357_9BDF, 128'h88);
        run_to_round(7);
        apply_reset();
        run_until_valid(30, n);
        check("reset_no_valid", 128'(n), -128'sd1);

        // Table-driven jobs.
        foreach (vecs[i]) begin
            submit(vecs[i].pt, vecs[i].key);
            if (vecs[i].abort_at >= 0) begin
                run_to_round(vecs[i].abort_at);
                abort = 1'b1;
                tick();
                abort = 1'b0;
            end
            run_until_valid(30, n);
            check("vec_done", 128'(n > 0), 128'(vecs[i].exp_done));
            if (n > 0) begin
                check("vec_ct", 128'(out_ct), 128'(vecs[i].exp_ct));
                for (int s = 0; s < vecs[i].stall; s++) tick();
                out_ready = 1'b1;
                tick();
                out_ready = 1'b0;
            end
        end

        // Randomized traffic against the reference model.
        for (int c = 0; c < 1500; c++) begin
            in_valid  = ($urandom_range(0, 3) == 0);
            in_pt     = {$urandom, $urandom};
            in_key    = {$urandom, $urandom, $urandom, $urandom};
            out_ready = $urandom_range(0, 1) == 1;
            abort     = ($urandom_range(0, 59) == 0);
            tick();
        end
        abort    = 1'b0;
        in_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_boron_ctrl
